pb_debounce_onepulse: RTL and testbench

//  Conditions raw push-button inputs for the lab designs. Consumes clk_150, the slow

---
 rtl/pb_debounce_onepulse_pkg.sv | 22 ++
 rtl/pb_debounce_onepulse_channel.sv | 139 +++++++++++++
 rtl/pb_debounce_onepulse.sv | 63 ++++++
 tb/tb_pb_debounce_onepulse.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pb_debounce_onepulse_pkg.sv
// Shared definitions for the push-button debouncer: channel FSM encodings,
// default parameter values and the long-press counter width helper.
package pb_debounce_onepulse_pkg;

    typedef enum logic [1:0] {
        PbIdle  = 2'd0,
        PbPress = 2'd1,
        PbLong  = 2'd2
    } pb_state_e;

    localparam int unsigned PbDefaultNPb       = 4;
    localparam int unsigned PbDefaultDepth     = 4;
    localparam int unsigned PbDefaultLongTicks = 150;

    // Bits needed to hold 0..ticks without wrapping; never less than one bit.
    function automatic int unsigned pb_cnt_width(input int unsigned ticks);
        int unsigned w;
        w = $clog2(ticks + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pb_debounce_onepulse_channel.sv
// One push-button channel: input synchronizer, DEPTH-sample shift register,
// debounced level, press FSM and (with PB_LONG_PRESS_EN) the long-press counter.
// Optional feature macro: PB_LONG_PRESS_EN.
module pb_debounce_onepulse_channel
    import pb_debounce_onepulse_pkg::*;
#(
    parameter int unsigned DEPTH      = PbDefaultDepth,
    parameter int unsigned LONG_TICKS = PbDefaultLongTicks
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick_i,
    input  logic pb_raw_i,
    output logic level_o,
    output logic pulse_o,
    output logic long_pulse_o
);

    logic             sync1_q, sync2_q;
    logic [DEPTH-1:0] shift_q, shift_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    pb_state_e        state_q, state_d;

`ifdef PB_LONG_PRESS_EN
    localparam int unsigned         CntW    = pb_cnt_width(LONG_TICKS);
    localparam logic [CntW-1:0]     LongMax = CntW'(LONG_TICKS);
    localparam logic [CntW-1:0]     CntOne  = CntW'(1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            long_q, long_d;
`else
    // LONG_TICKS only matters when the long-press feature is built.
    if (LONG_TICKS == 0) begin : g_long_ticks_unused
    end
`endif

    // Two-flop synchronizer for the asynchronous button pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pb_raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Shift a new sample in only on the debounce tick; level follows unanimous history.
    always_comb begin
        shift_d = shift_q;
        if (tick_i) begin
            shift_d = {shift_q[DEPTH-2:0], sync2_q};
        end
        level_d = level_q;
        if (&shift_q) begin
            level_d = 1'b1;
        end else if (~|shift_q) begin
            level_d = 1'b0;
        end
    end

    // Press FSM: pulse on the debounced rise, optional long-press detection.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
`ifdef PB_LONG_PRESS_EN
        cnt_d   = cnt_q;
        long_d  = 1'b0;
`endif
        unique case (state_q)
            PbIdle: begin
                if (level_d && !level_q) begin
                    state_d = PbPress;
                    pulse_d = 1'b1;
                end
            end
            PbPress: begin
                if (!level_d) begin
                    state_d = PbIdle;
`ifdef PB_LONG_PRESS_EN
                    cnt_d   = '0;
                end else if (tick_i && level_q && (cnt_q != LongMax)) begin
                    cnt_d = cnt_q + CntOne;
                    if ((cnt_q + CntOne) == LongMax) begin
                        state_d = PbLong;
                        long_d  = 1'b1;
                    end
`endif
                end
            end
            PbLong: begin
                if (!level_d) begin
                    state_d = PbIdle;
`ifdef PB_LONG_PRESS_EN
                    cnt_d   = '0;
`endif
                end
            end
            default: state_d = PbIdle;
        endcase
    end

    // Sample history, debounced level and FSM registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            state_q <= PbIdle;
        end else begin
            shift_q <= shift_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            state_q <= state_d;
        end
    end

`ifdef PB_LONG_PRESS_EN
    // Long-press counter and its one-clock output pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            long_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            long_q <= long_d;
        end
    end

    assign long_pulse_o = long_q;
`else
    assign long_pulse_o = 1'b0;
`endif

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/pb_debounce_onepulse.sv
// Push-button conditioner: synchronizes the slow clk_150 strobe into a one-clock
// tick shared by N_PB independent debounce/one-pulse channels.
// Optional feature macro: PB_LONG_PRESS_EN (long-press pulses on pb_long_o).
module pb_debounce_onepulse
    import pb_debounce_onepulse_pkg::*;
#(
    parameter int unsigned N_PB       = PbDefaultNPb,
    parameter int unsigned DEPTH      = PbDefaultDepth,
    parameter int unsigned LONG_TICKS = PbDefaultLongTicks
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_150_i,
    input  logic [N_PB-1:0] pb_in_i,
    output logic [N_PB-1:0] pb_level_o,
    output logic [N_PB-1:0] pb_pulse_o,
    output logic [N_PB-1:0] pb_long_o
);

    logic c150_s1_q, c150_s2_q, c150_prev_q;
    logic armed_q, armed_d;
    logic c150_rise;
    logic tick;

    // The first synced rising edge after reset only arms the tick generator,
    // so a clk_150 already high at reset release cannot fake a sample strobe.
    always_comb begin
        c150_rise = c150_s2_q & ~c150_prev_q;
        tick      = c150_rise & armed_q;
        armed_d   = armed_q | c150_rise;
    end

    // clk_150 synchronizer, edge-detect history and arm flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c150_s1_q   <= 1'b0;
            c150_s2_q   <= 1'b0;
            c150_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            c150_s1_q   <= clk_150_i;
            c150_s2_q   <= c150_s1_q;
            c150_prev_q <= c150_s2_q;
            armed_q     <= armed_d;
        end
    end

    for (genvar i = 0; i < N_PB; i++) begin : g_ch
        pb_debounce_onepulse_channel #(
            .DEPTH      (DEPTH),
            .LONG_TICKS (LONG_TICKS)
        ) u_channel (
            .clk          (clk),
            .rst_n        (rst_n),
            .tick_i       (tick),
            .pb_raw_i     (pb_in_i[i]),
            .level_o      (pb_level_o[i]),
            .pulse_o      (pb_pulse_o[i]),
            .long_pulse_o (pb_long_o[i])
        );
    end

endmodule

// File: tb/tb_pb_debounce_onepulse.sv
// Directed bench for pb_debounce_onepulse (N_PB=4, DEPTH=4, LONG_TICKS=8,
// clk_150 toggling every 8 clk so a tick arrives every 16 clk).
module tb_pb_debounce_onepulse;

    logic       clk;
    logic       rst_n;
    logic       clk_150;
    logic [3:0] pb_in;
    logic [3:0] pb_level;
    logic [3:0] pb_pulse;
    logic [3:0] pb_long;

    int checks = 0;
    int errors = 0;

    // Event counters kept by the monitor; the stimulus only snapshots them.
    int   pulse_cnt [4];
    int   long_cnt  [4];
    int   wide_cnt;
    logic [3:0] prev_pulse;

    int ps [4];
    int ls [4];
    int ws;

    pb_debounce_onepulse #(
        .N_PB       (4),
        .DEPTH      (4),
        .LONG_TICKS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_150_i  (clk_150),
        .pb_in_i    (pb_in),
        .pb_level_o (pb_level),
        .pb_pulse_o (pb_pulse),
        .pb_long_o  (pb_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        clk_150 = 1'b0;
        #3;
        forever #80 clk_150 = ~clk_150;
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            pulse_cnt[i] = 0;
            long_cnt[i]  = 0;
        end
        wide_cnt   = 0;
        prev_pulse = 4'b0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (pb_pulse[i] === 1'b1) pulse_cnt[i]++;
            if (pb_pulse[i] === 1'b1 && prev_pulse[i] === 1'b1) wide_cnt++;
            if (pb_long[i] === 1'b1) long_cnt[i]++;
        end
        prev_pulse = pb_pulse;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 4; i++) begin
            ps[i] = pulse_cnt[i];
            ls[i] = long_cnt[i];
        end
        ws = wide_cnt;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns the number of negedges waited; bound+1 means the level never rose.
    task automatic wait_level(input int ch, input int bound, output int t);
        t = 0;
        while (pb_level[ch] !== 1'b1 && t <= bound) begin
            @(negedge clk);
            t++;
        end
    endtask

    int t;
    int drops;
    int t_long;

    initial begin
        rst_n = 1'b0;
        pb_in = 4'b0000;
        cycles(2);
        check("reset_level", pb_level, 0);
        check("reset_pulse", pb_pulse, 0);
        check("reset_long", pb_long, 0);
        rst_n = 1'b1;
        cycles(40);

        // 1: clean press of channel 0
        snap();
        pb_in[0] = 1'b1;
        wait_level(0, 100, t);
        check_range("t1_latency", t, 52, 67);
        check("t1_pulse_with_level", pb_pulse[0], 1);
        cycles(100 - t);
        check("t1_pulse_count", pulse_cnt[0] - ps[0], 1);
        check("t1_pulse_width", wide_cnt - ws, 0);
        check("t1_other_pulses", (pulse_cnt[1] - ps[1]) + (pulse_cnt[2] - ps[2])
              + (pulse_cnt[3] - ps[3]), 0);
        check("t1_other_levels", pb_level[3:1], 0);
        pb_in[0] = 1'b0;
        cycles(100);
        check("t1_release_level", pb_level[0], 0);
        check("t1_no_release_pulse", pulse_cnt[0] - ps[0], 1);

        // 2: bouncing channel 1, then stable high
        snap();
        for (int k = 0; k < 12; k++) begin
            pb_in[1] = ~pb_in[1];
            cycles(5);
        end
        check("t2_bounce_pulses", pulse_cnt[1] - ps[1], 0);
        check("t2_bounce_level", pb_level[1], 0);
        pb_in[1] = 1'b1;
        wait_level(1, 100, t);
        check_range("t2_latency", t, 1, 67);
        check("t2_pulse_with_level", pb_pulse[1], 1);
        cycles(40);
        check("t2_single_pulse", pulse_cnt[1] - ps[1], 1);
        pb_in[1] = 1'b0;
        cycles(100);
        check("t2_release_level", pb_level[1], 0);

        // 3: one-tick low dip on channel 2 while its level is high
        pb_in[2] = 1'b1;
        wait_level(2, 100, t);
        check_range("t3_latency", t, 52, 67);
        cycles(2);
        snap();
        pb_in[2] = 1'b0;
        cycles(16);
        pb_in[2] = 1'b1;
        drops = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (pb_level[2] !== 1'b1) drops++;
        end
        check("t3_level_held", drops, 0);
        check("t3_no_new_pulse", pulse_cnt[2] - ps[2], 0);
        pb_in[2] = 1'b0;
        cycles(100);
        check("t3_release_level", pb_level[2], 0);

        // 4: channels 0 and 3 pressed in the same clock
        snap();
        pb_in = 4'b1001;
        wait_level(0, 100, t);
        check_range("t4_latency", t, 52, 67);
        check("t4_pulses_together", pb_pulse, 4'b1001);
        check("t4_levels_together", pb_level, 4'b1001);
        cycles(20);
        check("t4_pulse_count0", pulse_cnt[0] - ps[0], 1);
        check("t4_pulse_count3", pulse_cnt[3] - ps[3], 1);

        // 5: reset while channels 0 and 3 are pressed
        rst_n = 1'b0;
        #1;
        check("t5_async_level", pb_level, 0);
        check("t5_async_pulse", pb_pulse, 0);
        check("t5_async_long", pb_long, 0);
        cycles(3);
        rst_n = 1'b1;
        snap();
        wait_level(0, 120, t);
        check_range("t5_latency", t, 48, 90);
        check("t5_fresh_pulse", pb_pulse, 4'b1001);
        cycles(20);
        check("t5_pulse_count", pulse_cnt[0] - ps[0], 1);
        pb_in = 4'b0000;
        cycles(100);
        check("t5_release_levels", pb_level, 0);

        // 6: long hold on channel 1
        snap();
        pb_in[1] = 1'b1;
        wait_level(1, 100, t);
        check_range("t6_latency", t, 52, 67);
        t_long = -1;
        for (int k = 1; k <= 320; k++) begin
            @(negedge clk);
            if (pb_long[1] === 1'b1 && t_long < 0) t_long = k;
        end
`ifdef PB_LONG_PRESS_EN
        check("t6_long_delay", t_long, 127);
        check("t6_long_count", long_cnt[1] - ls[1], 1);
`else
        check("t6_long_absent", t_long, -1);
        check("t6_long_count", long_cnt[1] - ls[1], 0);
`endif
        pb_in[1] = 1'b0;
        cycles(100);
        check("t6_release_level", pb_level[1], 0);
        pb_in[1] = 1'b1;
        wait_level(1, 100, t);
        check("t6_rearm_pulse", pb_pulse[1], 1);
        cycles(140);
`ifdef PB_LONG_PRESS_EN
        check("t6_rearm_long", long_cnt[1] - ls[1], 2);
`else
        check("t6_rearm_long", long_cnt[1] - ls[1], 0);
`endif
        check("t6_other_long", (long_cnt[0] - ls[0]) + (long_cnt[2] - ls[2])
              + (long_cnt[3] - ls[3]), 0);
        pb_in[1] = 1'b0;
        cycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
